// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg
// Shared definitions for the instruction-fetch stage.
// Contents:
//   fetch_state_e     - fetch FSM state encoding (S_REQ/S_WAIT/S_FULL/S_STOP)
//   RESET_PC_DEFAULT  - default fetch address after reset
//   PC_STEP           - sequential instruction stride in bytes
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // issuing a request for fetch_pc
        S_WAIT = 2'd1,  // request accepted, waiting for read data
        S_FULL = 2'd2,  // read data parked in hold register, output busy
        S_STOP = 2'd3   // fetch halted after a misaligned fetch address
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
// Bundles the fetch stage's neighbours: decode-side branch decision,
// commit-side exception redirect, the SRAM-like instruction bus and the
// fetch->decode output handshake.
// Modports:
//   master - the fetch unit (drives inst_req/inst_addr and the if_* outputs)
//   slave  - the environment (bus, decode, commit)
// Handshakes:
//   Instruction bus: a request transfers when inst_req && inst_addr_ok in the
//   same cycle; inst_addr is sampled only then and may change while
//   unaccepted. Read data returns later as a one-cycle inst_data_ok pulse.
//   Fetch->decode: if_valid is the valid, id_allowin the ready; the
//   instruction moves to decode on a cycle where both are high.
interface fetch_pc_unit_if;

    logic        branch_en;
    logic [31:0] branch_target;
    logic        exc_flush;
    logic [31:0] exc_pc;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;
    logic        id_allowin;

    modport master (
        input  branch_en, branch_target, exc_flush, exc_pc,
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output if_valid, if_pc, if_inst, if_adel,
        input  id_allowin
    );

    modport slave (
        output branch_en, branch_target, exc_flush, exc_pc,
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  if_valid, if_pc, if_inst, if_adel,
        output id_allowin
    );

endinterface

// File: rtl/fetch_pc_unit_sel.sv
// fetch_pc_unit_sel
// Next-fetch-PC priority mux: exception redirect > taken branch (delay slot
// already delivered) > deferred branch target > sequential +4 > hold.
// Ports:
//   flush/flush_pc       - exception redirect and its address
//   redirect/redirect_pc - taken branch whose delay slot is leaving fetch now
//   advance              - current fetch_pc's instruction enters the output reg
//   pending/pending_pc   - branch target to use instead of +4 on advance
//   cur_pc               - current fetch_pc
//   next_pc              - fetch_pc for the next cycle (modulo 2^32)
module fetch_pc_unit_sel
    import fetch_pc_unit_pkg::*;
(
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    input  logic        pending,
    input  logic [31:0] pending_pc,
    input  logic [31:0] cur_pc,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = cur_pc;
        if (flush) begin
            next_pc = flush_pc;
        end else if (redirect) begin
            next_pc = redirect_pc;
        end else if (advance && pending) begin
            next_pc = pending_pc;
        end else if (advance) begin
            next_pc = cur_pc + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Instruction-fetch stage: owns the PC, keeps at most one request
// outstanding on the instruction bus and hands one instruction at a time to
// decode. Honours the branch delay slot and exception redirects.
// Ports:
//   clk    - clock
//   resetn - synchronous active-low reset
//   bus    - fetch_pc_unit_if.master (branch, flush, inst bus, output regs)
//   state  - current fetch FSM state, for observation
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   resetn,
    fetch_pc_unit_if.master        bus,
    output fetch_state_e           state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc, next_pc, pend_target, hold_inst;
    logic         pending_branch, cancel, cancel_d;
    logic         if_valid_q, if_adel_q;
    logic [31:0]  if_pc_q, if_inst_q;

    logic taken, redirect, slot_free, pc_bad, req_fire, outstanding;
    logic load_mem, load_hold, load_adel, store_hold, advance, any_load;

    assign state          = state_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.if_pc      = if_pc_q;
    assign bus.if_inst    = if_inst_q;
    assign bus.if_adel    = if_adel_q;

    assign pc_bad         = |fetch_pc[1:0];
    assign bus.inst_req   = resetn && (state_q == S_REQ) && !pc_bad;
    assign bus.inst_addr  = fetch_pc;
    assign req_fire       = bus.inst_req && bus.inst_addr_ok;

    // The branch in decode only counts once it actually leaves decode.
    assign taken     = bus.branch_en && bus.id_allowin;
    // Delay slot is in the output register: anything fetched after it is
    // wrong-path and fetch restarts at the target immediately.
    assign redirect  = taken && if_valid_q;
    assign slot_free = !if_valid_q || bus.id_allowin;
    // A request whose data has not come back by the end of this cycle.
    assign outstanding = ((state_q == S_WAIT) && !bus.inst_data_ok) || req_fire;

    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel;
        load_mem   = 1'b0;
        load_hold  = 1'b0;
        load_adel  = 1'b0;
        store_hold = 1'b0;
        case (state_q)
            S_REQ: begin
                if (pc_bad) begin
                    if (slot_free && !redirect) begin
                        load_adel = 1'b1;
                        state_d   = S_STOP;
                    end
                end else if (req_fire) begin
                    state_d = S_WAIT;
                    if (redirect) cancel_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (cancel) begin
                        cancel_d = 1'b0;
                        state_d  = S_REQ;
                    end else if (redirect) begin
                        // Returning word follows the delay slot: drop it.
                        state_d = S_REQ;
                    end else if (slot_free) begin
                        load_mem = 1'b1;
                        state_d  = S_REQ;
                    end else begin
                        store_hold = 1'b1;
                        state_d    = S_FULL;
                    end
                end else if (redirect) begin
                    cancel_d = 1'b1;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (bus.id_allowin) begin
                    load_hold = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_STOP: begin
            end
            default: state_d = S_REQ;
        endcase
        // Exception redirect wins over everything decided above. With a
        // request still in flight the new fetch waits for its data to drain.
        if (bus.exc_flush) begin
            load_mem   = 1'b0;
            load_hold  = 1'b0;
            load_adel  = 1'b0;
            store_hold = 1'b0;
            cancel_d   = outstanding;
            state_d    = outstanding ? S_WAIT : S_REQ;
        end
    end

    assign advance  = load_mem || load_hold;
    assign any_load = advance || load_adel;

    fetch_pc_unit_sel u_sel (
        .flush       (bus.exc_flush),
        .flush_pc    (bus.exc_pc),
        .redirect    (redirect),
        .redirect_pc (bus.branch_target),
        .advance     (advance),
        // A branch taken while the delay slot loads this very cycle uses
        // the live target instead of the registered one.
        .pending     (pending_branch || (taken && !if_valid_q)),
        .pending_pc  (pending_branch ? pend_target : bus.branch_target),
        .cur_pc      (fetch_pc),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_REQ;
            fetch_pc       <= RESET_PC;
            cancel         <= 1'b0;
            pending_branch <= 1'b0;
            pend_target    <= 32'd0;
            hold_inst      <= 32'd0;
            if_valid_q     <= 1'b0;
            if_pc_q        <= 32'd0;
            if_inst_q      <= 32'd0;
            if_adel_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            fetch_pc <= next_pc;
            cancel   <= cancel_d;

            if (bus.exc_flush || any_load) begin
                pending_branch <= 1'b0;
            end else if (taken && !if_valid_q) begin
                pending_branch <= 1'b1;
                pend_target    <= bus.branch_target;
            end

            if (store_hold) hold_inst <= bus.inst_rdata;

            if (load_mem) begin
                if_pc_q   <= fetch_pc;
                if_inst_q <= bus.inst_rdata;
                if_adel_q <= 1'b0;
            end else if (load_hold) begin
                if_pc_q   <= fetch_pc;
                if_inst_q <= hold_inst;
                if_adel_q <= 1'b0;
            end else if (load_adel) begin
                if_pc_q   <= fetch_pc;
                if_inst_q <= 32'd0;
                if_adel_q <= 1'b1;
            end

            if (bus.exc_flush)          if_valid_q <= 1'b0;
            else if (any_load)          if_valid_q <= 1'b1;
            else if (bus.id_allowin)    if_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
// Directed bench for fetch_pc_unit with a one-outstanding instruction bus
// model. Delivered PCs and accepted request addresses are predicted into
// queues by the directed steps and compared as the DUT produces them.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    fetch_state_e dut_state;
    fetch_pc_unit_if bus_if();

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];

    logic        bus_pend = 1'b0;
    logic [31:0] bus_addr = 32'd0;
    logic        ok_en = 1'b1;
    logic        data_en = 1'b1;

    fetch_pc_unit #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if),
        .state  (dut_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        return (a ^ 32'h5A5A_0F0F) + 32'h0000_0111;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive the bus model, score deliveries/requests, step the edge.
    task automatic cycle();
        logic [31:0] e;
        logic        acc;
        #1;
        bus_if.inst_data_ok = bus_pend && data_en;
        bus_if.inst_rdata   = (bus_pend && data_en) ? data_for(bus_addr) : 32'hDEAD_BEEF;
        bus_if.inst_addr_ok = bus_if.inst_req && ok_en;
        #1;
        if (bus_if.if_valid && bus_if.id_allowin && !bus_if.exc_flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_delivery: observed pc %h expected none", bus_if.if_pc);
            end else begin
                e = exp_q.pop_front();
                check("deliver_pc", bus_if.if_pc, e);
                check("deliver_inst", bus_if.if_inst, (e[1:0] != 2'b00) ? 32'd0 : data_for(e));
                check("deliver_adel", {31'd0, bus_if.if_adel}, {31'd0, e[1:0] != 2'b00});
            end
        end
        acc = bus_if.inst_req && bus_if.inst_addr_ok;
        if (acc) begin
            accepts++;
            if (exp_addr_q.size() > 0) check("req_addr", bus_if.inst_addr, exp_addr_q.pop_front());
        end
        if (bus_if.inst_data_ok) bus_pend = 1'b0;
        if (acc) begin
            bus_pend = 1'b1;
            bus_addr = bus_if.inst_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        bus_if.id_allowin = 1'b1;
        while (exp_q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        bus_if.id_allowin = 1'b0;
    endtask

    task automatic flush_to(input logic [31:0] pc);
        bus_if.exc_flush = 1'b1;
        bus_if.exc_pc    = pc;
        cycle();
        bus_if.exc_flush = 1'b0;
    endtask

    initial begin
        bus_if.branch_en     = 1'b0;
        bus_if.branch_target = 32'd0;
        bus_if.exc_flush     = 1'b0;
        bus_if.exc_pc        = 32'd0;
        bus_if.inst_addr_ok  = 1'b0;
        bus_if.inst_data_ok  = 1'b0;
        bus_if.inst_rdata    = 32'd0;
        bus_if.id_allowin    = 1'b0;

        // Reset
        resetn = 1'b0;
        cycle();
        check("reset_req", {31'd0, bus_if.inst_req}, 32'd0);
        cycle();
        check("reset_valid", {31'd0, bus_if.if_valid}, 32'd0);
        check("reset_pc", bus_if.if_pc, 32'd0);
        check("reset_inst", bus_if.if_inst, 32'd0);
        check("reset_adel", {31'd0, bus_if.if_adel}, 32'd0);
        check("reset_addr", bus_if.inst_addr, 32'hBFC0_0000);
        check("reset_state", 32'(dut_state), 32'(S_REQ));
        resetn = 1'b1;

        // Sequential fetch on a zero-wait bus
        exp_addr_q = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
        exp_q      = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_000C};
        drain();
        check("seq_addr_all_seen", 32'(exp_addr_q.size()), 32'd0);

        // Decode stalls: one word in output, one in hold, bus goes quiet
        accepts = 0;
        repeat (4) cycle();
        check("stall_accepts", 32'(accepts), 32'd1);
        check("stall_state", 32'(dut_state), 32'(S_FULL));
        check("stall_req", {31'd0, bus_if.inst_req}, 32'd0);
        check("stall_valid", {31'd0, bus_if.if_valid}, 32'd1);
        check("stall_pc", bus_if.if_pc, 32'hBFC0_0010);
        exp_q = '{32'hBFC0_0010, 32'hBFC0_0014, 32'hBFC0_0018};
        drain();

        // Taken branch, delay slot already in the output register
        flush_to(32'hBFC0_0000);
        check("flush1_valid", {31'd0, bus_if.if_valid}, 32'd0);
        check("flush1_addr", bus_if.inst_addr, 32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0000);
        drain();
        cycle();
        check("slot_valid", {31'd0, bus_if.if_valid}, 32'd1);
        check("slot_pc", bus_if.if_pc, 32'hBFC0_0004);
        exp_q = '{32'hBFC0_0004, 32'hBFC0_0100};
        bus_if.branch_en     = 1'b1;
        bus_if.branch_target = 32'hBFC0_0100;
        bus_if.id_allowin    = 1'b1;
        cycle();
        bus_if.branch_en = 1'b0;
        check("br1_state", 32'(dut_state), 32'(S_WAIT));
        check("br1_addr", bus_if.inst_addr, 32'hBFC0_0100);
        drain();

        // Taken branch while the delay slot is still in flight
        flush_to(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0000);
        drain();
        data_en = 1'b0;
        exp_q = '{32'hBFC0_0004, 32'hBFC0_0100};
        bus_if.branch_en     = 1'b1;
        bus_if.branch_target = 32'hBFC0_0100;
        bus_if.id_allowin    = 1'b1;
        cycle();
        bus_if.branch_en = 1'b0;
        check("br2_state", 32'(dut_state), 32'(S_WAIT));
        check("br2_addr_hold", bus_if.inst_addr, 32'hBFC0_0004);
        data_en = 1'b1;
        cycle();
        check("br2_slot_pc", bus_if.if_pc, 32'hBFC0_0004);
        check("br2_addr_target", bus_if.inst_addr, 32'hBFC0_0100);
        drain();

        // Exception flush while a request is outstanding
        cycle();
        cycle();
        check("pre_flush_state", 32'(dut_state), 32'(S_WAIT));
        data_en = 1'b0;
        flush_to(32'hBFC0_0380);
        check("flush2_valid", {31'd0, bus_if.if_valid}, 32'd0);
        check("flush2_state", 32'(dut_state), 32'(S_WAIT));
        check("flush2_req", {31'd0, bus_if.inst_req}, 32'd0);
        check("flush2_addr", bus_if.inst_addr, 32'hBFC0_0380);
        data_en = 1'b1;
        exp_addr_q.push_back(32'hBFC0_0380);
        exp_q.push_back(32'hBFC0_0380);
        drain();
        check("flush2_addr_seen", 32'(exp_addr_q.size()), 32'd0);

        // Misaligned redirect: AdEL delivered, fetch stops
        flush_to(32'hBFC0_0382);
        check("adel_pre_state", 32'(dut_state), 32'(S_REQ));
        check("adel_req", {31'd0, bus_if.inst_req}, 32'd0);
        cycle();
        check("adel_valid", {31'd0, bus_if.if_valid}, 32'd1);
        check("adel_pc", bus_if.if_pc, 32'hBFC0_0382);
        check("adel_inst", bus_if.if_inst, 32'd0);
        check("adel_flag", {31'd0, bus_if.if_adel}, 32'd1);
        check("adel_state", 32'(dut_state), 32'(S_STOP));
        exp_q.push_back(32'hBFC0_0382);
        drain();
        accepts = 0;
        repeat (3) cycle();
        check("stop_accepts", 32'(accepts), 32'd0);
        check("stop_state", 32'(dut_state), 32'(S_STOP));
        check("stop_valid", {31'd0, bus_if.if_valid}, 32'd0);

        // Redirect near the top of the address space: PC wraps to 0
        flush_to(32'hFFFF_FFFC);
        check("wrap_state", 32'(dut_state), 32'(S_REQ));
        exp_addr_q = '{32'hFFFF_FFFC, 32'h0000_0000};
        exp_q      = '{32'hFFFF_FFFC, 32'h0000_0000};
        drain();
        check("wrap_addr_seen", 32'(exp_addr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the PC and issues single-outstanding requests on the SRAM-like instruction bus.
- Delivers one instruction at a time to decode through a valid/allowin handshake.
- Consumes branchEn/branchTarget from the decode-stage branch decision unit, honours the branch delay slot, and redirects on exception flush.

Parameters:
RESET_PC, 32'hBFC00000, fetch address after reset

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
branchEn  in  1  taken-branch decision for the instruction currently in decode
branchTarget  in  32  branch/jump target, valid with branchEn
excFlush  in  1  exception/eret redirect from commit
excPc  in  32  redirect address, valid with excFlush
instReq  out  1  instruction bus request
instAddr  out  32  request address
instAddrOk  in  1  request accepted this cycle
instDataOk  in  1  read data returned this cycle
instRdata  in  32  read data
ifValid  out  1  output register holds an instruction
ifPc  out  32  PC of output instruction
ifInst  out  32  output instruction word
ifAdEL  out  1  output instruction has a misaligned fetch address
idAllowin  in  1  decode accepts output this cycle

Behaviour:
- Reset (resetn=0 at posedge):
  - fetchPc=RESET_PC; state=S_REQ.
  - ifValid=0, ifPc=0, ifInst=0, ifAdEL=0; pendingBranch=0, cancel=0.
  - instReq forced 0 while resetn=0.
- States:
  - S_REQ: instReq=1, instAddr=fetchPc.
  - S_WAIT: request accepted, awaiting data.
  - S_FULL: data held in internal hold register because output is busy.
  - S_STOP: fetch halted after AdEL.
- Address sampling: the bus samples instAddr only on an instAddrOk cycle. instAddr may change while unaccepted.
- S_REQ:
  - instAddrOk=1 -> S_WAIT.
  - fetchPc[1:0]!=0: no request (instReq=0). When the output slot is free (!ifValid or idAllowin), load ifPc=fetchPc, ifInst=0, ifAdEL=1, ifValid=1 -> S_STOP.
- S_WAIT, instDataOk=1:
  - cancel=1: drop data, cancel<=0 -> S_REQ.
  - Else if !ifValid or idAllowin: load output (ifValid=1, ifAdEL=0), fetchPc+=4 -> S_REQ.
  - Else: store into hold -> S_FULL.
- S_FULL, idAllowin=1: output<=hold, fetchPc+=4 -> S_REQ.
- Output handshake: ifValid clears when idAllowin=1 and no new load occurs that cycle. Fetch latency is 1 cycle from instDataOk to ifValid, with zero-wait bus.
- Branch (taken = branchEn & idAllowin; the branch leaves decode):
  - ifValid=1: the output register is the delay slot and moves to decode normally. Discard hold (S_FULL -> S_REQ). Set fetchPc<=branchTarget. An in-flight request is wrong-path: if in S_WAIT, or in S_REQ with instAddrOk this cycle, set cancel.
  - ifValid=0: the delay slot is not yet delivered. pendingBranch<=1, pendTarget<=branchTarget. When the next instruction loads into the output register, fetchPc<=pendTarget instead of +4, and pendingBranch<=0.
- excFlush (highest priority, overrides branch and same-cycle loads):
  - ifValid<=0; hold discarded; pendingBranch<=0; fetchPc<=excPc.
  - Sets cancel if a request is outstanding: S_WAIT, or S_REQ with instAddrOk this cycle.
  - Next state: S_WAIT if cancel is now set (single outstanding; the new request waits for the stale data to drain), else S_REQ.
  - Leaves S_STOP.
- Width rules: all PC arithmetic is 32-bit modulo 2^32; wrap at 32'hFFFFFFFC -> 0 is silent.

Decomposition:
- defines.v: state encodings (S_REQ/S_WAIT/S_FULL/S_STOP), RESET_PC default, `TRUE/`FALSE.
- One natural combinational sub-module: fetch_pc_sel, the next-fetchPc priority mux (flush > branch > pending > +4).

Test Plan:
- Reset release, zero-wait bus: instAddr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive accepted requests. ifPc follows 1 cycle after each instDataOk.
- idAllowin=0 for 3 cycles with data returning: one word in output, one in hold. No further instReq; no loss; in-order delivery on release.
- Taken branch at 0xBFC00000 with delay slot 0xBFC00004 in output, target 0xBFC00100: in-flight 0xBFC00008 data dropped. Next delivered PC is 0xBFC00100.
- Taken branch with ifValid=0, delay slot still in flight: 0xBFC00004 delivered, then 0xBFC00100.
- excFlush to 0xBFC00380 during S_WAIT: stale data dropped, ifValid=0. Next request is 0xBFC00380.
- excPc=0xBFC00382: instReq stays 0; ifAdEL=1, ifPc=0xBFC00382, ifInst=0; state S_STOP until the next excFlush.
